window_seq_3x3: RTL and testbench
=================================

Name: window_seq_3x3

Overview:
- Frame-level sequencer for the 3x3 window datapath: the line-buffer taps and the 3x3 window register stage.
- Sits between the camera/pixel source and the window generator. It drives the line-buffer shift enable and shift data, appends one pad pixel per line, and injects one synthetic flush line after the last image line so the bottom row and right column become window centres.
- Emits window-aligned control: valid flag, centre coordinates, border flags, frame-done and error pulses.

Parameters:
- DATA_WIDTH, 8, pixel width.
- IMG_WIDTH, 640, active pixels per line. Downstream line-buffer depth shall be IMG_WIDTH+1.
- IMG_HEIGHT, 480, active lines per frame.
- FLUSH_GAP, 16, idle cycles between the end of the last line's pad and the start of the flush line.
- WIN_LAT, 2, cycles from buf_clken to the downstream window-register update. Control outputs are delayed to match.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous reset, active-high.
- per_frame_vsync  in  1  frame sync; rising edge starts a frame.
- per_frame_href  in  1  line valid; one pixel per cycle while high.
- per_img_y  in  DATA_WIDTH  pixel data.
- buf_clken  out  1  line-buffer shift enable (registered).
- buf_shiftin  out  DATA_WIDTH  line-buffer shift data (registered).
- win_vsync  out  1  per_frame_vsync delayed 1+WIN_LAT cycles.
- win_href  out  1  buf_clken delayed WIN_LAT cycles.
- win_valid  out  1  window centre lies inside the image.
- win_cx  out  clog2(IMG_WIDTH)  centre column.
- win_cy  out  clog2(IMG_HEIGHT)  centre row.
- win_top, win_bot, win_left, win_right  out  1 each  border flags (see Behaviour).
- frame_done  out  1  one-cycle pulse at flush completion.
- line_err  out  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset: state IDLE; every output 0; counters 0; vsync edge detector cleared.
- FSM states: IDLE, LINES, GAP, FLUSH, DONE.
- IDLE -> LINES on a vsync rising edge. In IDLE, href is ignored: no buf_clken, no line_err.
- LINES:
  - Each href-high cycle with in_col < IMG_WIDTH: buf_clken=1, buf_shiftin=per_img_y, in_col++.
  - Pixels with in_col >= IMG_WIDTH are dropped (buf_clken=0) and cause one line_err pulse per line.
  - On the first href-low cycle after a line, the block always injects one pad cycle: buf_clken=1, buf_shiftin=0.
  - After the pad: if in_col != IMG_WIDTH, line_err pulses. in_col is cleared and in_row increments. If in_row reaches IMG_HEIGHT, go to GAP.
- GAP: count FLUSH_GAP cycles, then go to FLUSH. href high during GAP or FLUSH: pixel ignored, line_err pulses once per offending line.
- FLUSH: drive IMG_WIDTH+1 consecutive cycles with buf_clken=1 and buf_shiftin=0, then go to DONE.
- DONE: frame_done=1 for one cycle, then go to IDLE.
- Vsync rising edge in LINES/GAP/FLUSH: abort, with no frame_done. Clear counters and re-enter LINES on the next cycle. The edge cycle itself produces no buf_clken.
- Window coordinates, computed at buf_clken time and delayed WIN_LAT cycles:
  - cy = in_row-1; the flush line uses cy = IMG_HEIGHT-1.
  - cx = shift_index-1, where shift_index is 0..IMG_WIDTH (the pad is index IMG_WIDTH).
- win_valid = win_href & (cy in 0..IMG_HEIGHT-1) & (cx in 0..IMG_WIDTH-1). Row 0 and shift_index 0 are never valid.
- Border flags: win_top = valid & cy==0; win_bot = valid & cy==IMG_HEIGHT-1; win_left = valid & cx==0; win_right = valid & cx==IMG_WIDTH-1.
- Border flags mark windows whose outer row/column holds stale or pad data.
- When win_valid=0, win_cx, win_cy and all border flags are 0.
- Counter widths: in_col 0..IMG_WIDTH, in_row 0..IMG_HEIGHT, gap counter 0..FLUSH_GAP-1. No wrap: counters saturate at their terminal values in the illegal cases above.
- Reset mid-frame: immediate return to reset values; the delay pipelines are also cleared.

Test Plan:
- Nominal frame, IMG_WIDTH=4, IMG_HEIGHT=3, FLUSH_GAP=2 -> buf_clken high for 5 cycles per line plus 5 flush cycles; exactly 12 win_valid cycles, cy 0..2, cx 0..3; frame_done once, 2+5+1 cycles after the last pad.
- Border check on the same frame -> win_top only on cy=0; win_bot only on cy=2 (flush line); win_left on cx=0; win_right on cx=3; corners assert two flags simultaneously.
- Short line (3 pixels on line 1) -> line_err pulse after that line's pad; frame still completes; frame_done asserted.
- Long line (6 pixels) -> pixels 5 and 6 produce no buf_clken; one line_err pulse; line count unaffected.
- Vsync rising edge during line 2 -> no frame_done; next frame counts from row 0; window output restarts with cy=0 only on the new frame's second line.
- rst asserted during FLUSH -> all outputs 0 next cycle; href before the next vsync edge produces no buf_clken and no line_err.

Source files
------------

// File: rtl/window_seq_3x3.sv
// window_seq_3x3: frame-level sequencer for the 3x3 window datapath.
//
// Sits between the pixel source and the line-buffer taps / 3x3 window register stage. Accepted
// pixels are forwarded into the line buffer. Each line gets one trailing pad pixel, so the
// buffer holds IMG_WIDTH+1 entries per line. After the last line and FLUSH_GAP idle cycles, one
// synthetic all-zero flush line pushes the bottom image row through the window centre.
// Window-aligned control (valid, centre coordinates, border flags) is computed when a shift
// happens and is delayed WIN_LAT cycles to line up with the downstream window registers.
//
// Ports:
//   clk              pixel clock
//   rst              synchronous reset, active-high
//   per_frame_vsync  frame sync; a rising edge starts (or restarts) a frame
//   per_frame_href   line valid; one pixel per cycle while high
//   per_img_y        pixel data
//   buf_clken        line-buffer shift enable (registered)
//   buf_shiftin      line-buffer shift data (registered)
//   win_vsync        per_frame_vsync delayed 1+WIN_LAT cycles
//   win_href         buf_clken delayed WIN_LAT cycles
//   win_valid        window centre lies inside the image
//   win_cx, win_cy   window centre column / row (0 when not valid)
//   win_top/bot/left/right  border flags (0 when not valid)
//   frame_done       one-cycle pulse when the flush line completes
//   line_err         one-cycle pulse on a protocol violation
module window_seq_3x3 #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned FLUSH_GAP  = 16,
  parameter int unsigned WIN_LAT    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          per_frame_vsync,
  input  logic                          per_frame_href,
  input  logic [DATA_WIDTH-1:0]         per_img_y,
  output logic                          buf_clken,
  output logic [DATA_WIDTH-1:0]         buf_shiftin,
  output logic                          win_vsync,
  output logic                          win_href,
  output logic                          win_valid,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_cx,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_cy,
  output logic                          win_top,
  output logic                          win_bot,
  output logic                          win_left,
  output logic                          win_right,
  output logic                          frame_done,
  output logic                          line_err
);

  localparam int unsigned CxW  = $clog2(IMG_WIDTH);
  localparam int unsigned CyW  = $clog2(IMG_HEIGHT);
  localparam int unsigned ColW = $clog2(IMG_WIDTH + 1);
  localparam int unsigned RowW = $clog2(IMG_HEIGHT + 1);
  localparam int unsigned GapW = (FLUSH_GAP > 1) ? $clog2(FLUSH_GAP) : 1;

  localparam logic [ColW-1:0] ColEnd = ColW'(IMG_WIDTH);
  localparam logic [RowW-1:0] RowEnd = RowW'(IMG_HEIGHT);
  localparam logic [GapW-1:0] GapEnd = GapW'(FLUSH_GAP - 1);
  localparam logic [CxW-1:0]  CxLast = CxW'(IMG_WIDTH - 1);
  localparam logic [CyW-1:0]  CyLast = CyW'(IMG_HEIGHT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLines,
    StGap,
    StFlush,
    StDone
  } state_e;

  // Window-aligned control word, carried down the WIN_LAT delay line.
  typedef struct packed {
    logic           href;
    logic           valid;
    logic [CxW-1:0] cx;
    logic [CyW-1:0] cy;
    logic           top;
    logic           bot;
    logic           left;
    logic           right;
  } win_t;

  state_e          state_q, state_d;
  logic [ColW-1:0] col_q, col_d;       // in_col during lines, shift index during flush
  logic [RowW-1:0] row_q, row_d;       // in_row
  logic [GapW-1:0] gap_q, gap_d;
  logic            act_q, act_d;       // current line has seen at least one href-high cycle
  logic            err_seen_q, err_seen_d;  // line_err already reported for this line

  logic                  clken_q, clken_d;
  logic [DATA_WIDTH-1:0] shiftin_q, shiftin_d;
  logic                  line_err_q, line_err_d;
  logic                  done_q, done_d;

  // Index 0 is aligned with buf_clken; index WIN_LAT drives the window outputs.
  win_t win_q [WIN_LAT+1];
  win_t win_d;
  // Index 0 doubles as the vsync edge detector.
  logic vs_q [WIN_LAT+1];
  logic vs_rise;

  // Shift index and source row of the pixel being shifted this cycle (0 when idle).
  logic [ColW-1:0] idx;
  logic [RowW-1:0] wrow;

  assign vs_rise = per_frame_vsync & ~vs_q[0];

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    gap_d      = gap_q;
    act_d      = act_q;
    err_seen_d = err_seen_q;
    clken_d    = 1'b0;
    shiftin_d  = '0;
    line_err_d = 1'b0;
    done_d     = 1'b0;
    idx        = '0;
    wrow       = '0;

    if (vs_rise) begin
      // Start or abort: the edge cycle itself shifts nothing. A frame that just finished
      // still gets its frame_done pulse.
      state_d    = StLines;
      col_d      = '0;
      row_d      = '0;
      gap_d      = '0;
      act_d      = 1'b0;
      err_seen_d = 1'b0;
      done_d     = (state_q == StDone);
    end else begin
      unique case (state_q)
        StIdle: begin
        end

        StLines: begin
          if (per_frame_href) begin
            act_d = 1'b1;
            if (col_q != ColEnd) begin
              clken_d   = 1'b1;
              shiftin_d = per_img_y;
              idx       = col_q;
              wrow      = row_q;
              col_d     = col_q + ColW'(1);
            end else if (!err_seen_q) begin
              // Excess pixel: dropped, reported once per line.
              line_err_d = 1'b1;
              err_seen_d = 1'b1;
            end
          end else if (act_q) begin
            // Pad pixel closes the line; a short line is reported here.
            clken_d    = 1'b1;
            idx        = ColEnd;
            wrow       = row_q;
            line_err_d = (col_q != ColEnd);
            col_d      = '0;
            act_d      = 1'b0;
            err_seen_d = 1'b0;
            row_d      = row_q + RowW'(1);
            if (row_q + RowW'(1) == RowEnd) begin
              state_d = StGap;
              gap_d   = '0;
            end
          end
        end

        StGap: begin
          if (gap_q == GapEnd) begin
            state_d = StFlush;
            col_d   = '0;
          end else begin
            gap_d = gap_q + GapW'(1);
          end
        end

        StFlush: begin
          clken_d = 1'b1;
          idx     = col_q;
          // Flush line behaves as row IMG_HEIGHT, so its centre row is the last image row.
          wrow    = RowEnd;
          if (col_q == ColEnd) begin
            state_d = StDone;
            col_d   = '0;
          end else begin
            col_d = col_q + ColW'(1);
          end
        end

        StDone: begin
          done_d     = 1'b1;
          state_d    = StIdle;
          row_d      = '0;
          gap_d      = '0;
          err_seen_d = 1'b0;
        end

        default: begin
          state_d = StIdle;
        end
      endcase

      // href during gap or flush is ignored; one error per offending href burst.
      if (state_q == StGap || state_q == StFlush) begin
        if (per_frame_href) begin
          if (!err_seen_q) begin
            line_err_d = 1'b1;
            err_seen_d = 1'b1;
          end
        end else begin
          err_seen_d = 1'b0;
        end
      end
    end
  end

  // Window centre is one behind the shifted pixel in both directions.
  always_comb begin
    win_d       = '0;
    win_d.href  = clken_d;
    win_d.valid = clken_d && (idx != '0) && (wrow != '0);
    if (win_d.valid) begin
      win_d.cx    = CxW'(idx - ColW'(1));
      win_d.cy    = CyW'(wrow - RowW'(1));
      win_d.top   = (win_d.cy == '0);
      win_d.bot   = (win_d.cy == CyLast);
      win_d.left  = (win_d.cx == '0);
      win_d.right = (win_d.cx == CxLast);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      col_q      <= '0;
      row_q      <= '0;
      gap_q      <= '0;
      act_q      <= 1'b0;
      err_seen_q <= 1'b0;
      clken_q    <= 1'b0;
      shiftin_q  <= '0;
      line_err_q <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i <= int'(WIN_LAT); i++) begin
        win_q[i] <= '0;
        vs_q[i]  <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      gap_q      <= gap_d;
      act_q      <= act_d;
      err_seen_q <= err_seen_d;
      clken_q    <= clken_d;
      shiftin_q  <= shiftin_d;
      line_err_q <= line_err_d;
      done_q     <= done_d;
      win_q[0]   <= win_d;
      vs_q[0]    <= per_frame_vsync;
      for (int i = 1; i <= int'(WIN_LAT); i++) begin
        win_q[i] <= win_q[i-1];
        vs_q[i]  <= vs_q[i-1];
      end
    end
  end

  assign buf_clken   = clken_q;
  assign buf_shiftin = shiftin_q;
  assign line_err    = line_err_q;
  assign frame_done  = done_q;
  assign win_vsync   = vs_q[WIN_LAT];
  assign win_href    = win_q[WIN_LAT].href;
  assign win_valid   = win_q[WIN_LAT].valid;
  assign win_cx      = win_q[WIN_LAT].cx;
  assign win_cy      = win_q[WIN_LAT].cy;
  assign win_top     = win_q[WIN_LAT].top;
  assign win_bot     = win_q[WIN_LAT].bot;
  assign win_left    = win_q[WIN_LAT].left;
  assign win_right   = win_q[WIN_LAT].right;

endmodule

// File: tb/tb_window_seq_3x3.sv
// Testbench for window_seq_3x3 with a 4x3 image, FLUSH_GAP=2, WIN_LAT=2.
module tb_window_seq_3x3;

  localparam int W = 4;
  localparam int H = 3;
  localparam int L = 2;
  localparam int NV = 27;

  logic       clk = 1'b0;
  logic       rst;
  logic       vs;
  logic       href;
  logic [7:0] y;
  logic       buf_clken;
  logic [7:0] buf_shiftin;
  logic       win_vsync, win_href, win_valid;
  logic [1:0] win_cx, win_cy;
  logic       win_top, win_bot, win_left, win_right;
  logic       frame_done, line_err;

  window_seq_3x3 #(
    .DATA_WIDTH(8),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .FLUSH_GAP (2),
    .WIN_LAT   (L)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .per_frame_vsync(vs),
    .per_frame_href (href),
    .per_img_y      (y),
    .buf_clken      (buf_clken),
    .buf_shiftin    (buf_shiftin),
    .win_vsync      (win_vsync),
    .win_href       (win_href),
    .win_valid      (win_valid),
    .win_cx         (win_cx),
    .win_cy         (win_cy),
    .win_top        (win_top),
    .win_bot        (win_bot),
    .win_left       (win_left),
    .win_right      (win_right),
    .frame_done     (frame_done),
    .line_err       (line_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: counts pulses and records every valid window.
  typedef struct packed {
    logic [1:0] cx;
    logic [1:0] cy;
    logic [3:0] fl;  // {top, bot, left, right}
  } win_rec_t;

  win_rec_t wq[$];
  int n_clken = 0;
  int n_err = 0;
  int n_done = 0;
  int n_bad_idle = 0;

  always @(negedge clk) begin
    win_rec_t r;
    if (buf_clken) n_clken++;
    if (line_err) n_err++;
    if (frame_done) n_done++;
    if (win_valid) begin
      r.cx = win_cx;
      r.cy = win_cy;
      r.fl = {win_top, win_bot, win_left, win_right};
      wq.push_back(r);
      if (!win_href) n_bad_idle++;
    end else if (win_cx != 2'd0 || win_cy != 2'd0 ||
                 {win_top, win_bot, win_left, win_right} != 4'd0) begin
      n_bad_idle++;
    end
  end

  typedef struct {
    logic       vs;
    logic       href;
    logic [7:0] y;
    logic       clken;
    logic [7:0] sh;
    logic       err;
    logic       done;
  } vec_t;

  vec_t tbl[NV];

  task automatic setv(input int i, input logic v, input logic h, input logic [7:0] yy,
                      input logic ck, input logic [7:0] sh);
    tbl[i].vs    = v;
    tbl[i].href  = h;
    tbl[i].y     = yy;
    tbl[i].clken = ck;
    tbl[i].sh    = sh;
    tbl[i].err   = 1'b0;
    tbl[i].done  = 1'b0;
  endtask

  task automatic send_line(input int n);
    for (int p = 0; p < n; p++) begin
      href = 1'b1;
      y    = 8'(p + 1);
      tick();
    end
    href = 1'b0;
    y    = 8'd0;
    tick();  // pad
    tick();  // separator
  endtask

  task automatic idle(input int n);
    vs   = 1'b0;
    href = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  function automatic int all_outs();
    return int'({buf_clken, buf_shiftin, win_vsync, win_href, win_valid, win_cx, win_cy,
                 win_top, win_bot, win_left, win_right, frame_done, line_err});
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int c0, e0, d0, wb;
    int j;
    win_rec_t r;

    // Nominal frame, cycle by cycle.
    for (int i = 0; i < NV; i++) setv(i, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    setv(0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    for (int l = 0; l < 3; l++) begin
      for (int p = 0; p < 4; p++) begin
        setv(1 + 6 * l + p, 1'b0, 1'b1, 8'(8'h11 + 16 * l + p), 1'b1, 8'(8'h11 + 16 * l + p));
      end
      setv(1 + 6 * l + 4, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
    end
    for (int i = 20; i <= 24; i++) setv(i, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
    tbl[25].done = 1'b1;

    // Reset state.
    rst  = 1'b1;
    vs   = 1'b0;
    href = 1'b0;
    y    = 8'd0;
    tick();
    tick();
    check("reset_outs", all_outs(), 0);
    rst = 1'b0;
    tick();
    check("post_reset_outs", all_outs(), 0);

    wb = wq.size();
    for (int i = 0; i < NV; i++) begin
      vs   = tbl[i].vs;
      href = tbl[i].href;
      y    = tbl[i].y;
      tick();
      check($sformatf("nom[%0d].clken", i), int'(buf_clken), int'(tbl[i].clken));
      check($sformatf("nom[%0d].shiftin", i), int'(buf_shiftin), int'(tbl[i].sh));
      check($sformatf("nom[%0d].line_err", i), int'(line_err), int'(tbl[i].err));
      check($sformatf("nom[%0d].frame_done", i), int'(frame_done), int'(tbl[i].done));
      j = i - L;
      check($sformatf("nom[%0d].win_href", i), int'(win_href),
            (j >= 0) ? int'(tbl[j].clken) : 0);
      check($sformatf("nom[%0d].win_vsync", i), int'(win_vsync),
            (j >= 0) ? int'(tbl[j].vs) : 0);
    end
    idle(3);
    check("nom_win_count", wq.size() - wb, 12);
    for (int k = 0; k < 12 && wb + k < wq.size(); k++) begin
      int ecx, ecy;
      ecx = k % 4;
      ecy = k / 4;
      r = wq[wb + k];
      check($sformatf("nom_win[%0d].cx", k), int'(r.cx), ecx);
      check($sformatf("nom_win[%0d].cy", k), int'(r.cy), ecy);
      check($sformatf("nom_win[%0d].flags", k), int'(r.fl),
            int'({ecy == 0, ecy == H - 1, ecx == 0, ecx == W - 1}));
    end

    // Short middle line.
    c0 = n_clken; e0 = n_err; d0 = n_done;
    vs = 1'b1; tick(); vs = 1'b0;
    send_line(4); send_line(3); send_line(4);
    idle(20);
    check("short_clken", n_clken - c0, 19);
    check("short_err", n_err - e0, 1);
    check("short_done", n_done - d0, 1);

    // Long middle line.
    c0 = n_clken; e0 = n_err; d0 = n_done; wb = wq.size();
    vs = 1'b1; tick(); vs = 1'b0;
    send_line(4); send_line(6); send_line(4);
    idle(20);
    check("long_clken", n_clken - c0, 20);
    check("long_err", n_err - e0, 1);
    check("long_done", n_done - d0, 1);
    check("long_wins", wq.size() - wb, 12);

    // Vsync edge in the middle of line 2.
    e0 = n_err; d0 = n_done;
    vs = 1'b1; tick(); vs = 1'b0;
    send_line(4);
    href = 1'b1; y = 8'd1; tick();
    y = 8'd2; tick();
    vs = 1'b1; y = 8'd3; tick();
    check("abort_edge_clken", int'(buf_clken), 0);
    idle(4);
    wb = wq.size();
    send_line(4); send_line(4); send_line(4);
    idle(20);
    check("abort_done", n_done - d0, 1);
    check("abort_err", n_err - e0, 0);
    check("abort_wins", wq.size() - wb, 12);
    if (wq.size() > wb) begin
      r = wq[wb];
      check("abort_first_cy", int'(r.cy), 0);
      check("abort_first_cx", int'(r.cx), 0);
    end

    // Reset during flush.
    d0 = n_done;
    vs = 1'b1; tick(); vs = 1'b0;
    send_line(4); send_line(4); send_line(4);
    tick(); tick(); tick();
    check("pre_rst_flush_clken", int'(buf_clken), 1);
    rst = 1'b1;
    tick();
    check("rst_flush_outs", all_outs(), 0);
    rst = 1'b0;
    c0 = n_clken; e0 = n_err;
    for (int k = 0; k < 6; k++) begin
      href = 1'b1; y = 8'(k + 7); tick();
    end
    idle(20);
    check("rst_href_clken", n_clken - c0, 0);
    check("rst_href_err", n_err - e0, 0);
    check("rst_done", n_done - d0, 0);

    check("invalid_window_fields", n_bad_idle, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
